// File: rtl/pwm_2ph.sv
// Two-phase PWM generator: phase A and a 180-degree shifted phase B share one
// period counter, with shadowed duty updates at period boundaries and a latched fault trip.
module pwm_2ph #(
    parameter int CNT_W    = 13,
    parameter int PERIOD   = 5000,
    parameter int DUTY_MAX = 4500,
    parameter int DUTY_RST = 0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [CNT_W-1:0] duty_in,
    input  logic             duty_wr,
    input  logic             fault_in,
    input  logic             fault_clr,
    output logic             pwm_a,
    output logic             pwm_b,
    output logic             period_start,
    output logic             fault_latched,
    output logic [CNT_W-1:0] duty_active
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_CAP = CNT_W'(DUTY_MAX);
    localparam logic [CNT_W-1:0] DUTY_INI = CNT_W'(DUTY_RST);
    localparam logic [CNT_W:0]   HALF_P   = (CNT_W + 1)'(PERIOD / 2);
    localparam logic [CNT_W:0]   FULL_P   = (CNT_W + 1)'(PERIOD);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] duty_q, duty_d;
    logic             pwm_a_q, pwm_a_d;
    logic             pwm_b_q, pwm_b_d;
    logic             pstart_q, pstart_d;
    logic             fault_q, fault_d;

    logic             run;
    logic [CNT_W-1:0] duty_clamped;
    logic [CNT_W:0]   cnt_b_sum;
    logic [CNT_W:0]   cnt_b;

    // A fault seen this cycle halts immediately, ahead of the latch itself.
    assign run          = enable & ~fault_q & ~fault_in;
    assign duty_clamped = (duty_in > DUTY_CAP) ? DUTY_CAP : duty_in;
    assign cnt_b_sum    = {1'b0, cnt_q} + HALF_P;
    assign cnt_b        = (cnt_b_sum >= FULL_P) ? (cnt_b_sum - FULL_P) : cnt_b_sum;

    always_comb begin
        cnt_d    = '0;
        shadow_d = duty_wr ? duty_clamped : shadow_q;
        duty_d   = duty_q;
        pwm_a_d  = 1'b0;
        pwm_b_d  = 1'b0;
        pstart_d = 1'b0;
        fault_d  = fault_q;

        if (run) begin
            cnt_d    = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
            pwm_a_d  = (cnt_q < duty_q);
            pwm_b_d  = (cnt_b < {1'b0, duty_q});
            pstart_d = (cnt_q == '0);
        end

        // Loading the next shadow value covers the same-cycle write bypass.
        if (!run || cnt_q == CNT_LAST) begin
            duty_d = shadow_d;
        end

        if (fault_in) begin
            fault_d = 1'b1;
        end else if (fault_clr) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            cnt_q    <= '0;
            shadow_q <= DUTY_INI;
            duty_q   <= DUTY_INI;
            pwm_a_q  <= 1'b0;
            pwm_b_q  <= 1'b0;
            pstart_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            duty_q   <= duty_d;
            pwm_a_q  <= pwm_a_d;
            pwm_b_q  <= pwm_b_d;
            pstart_q <= pstart_d;
            fault_q  <= fault_d;
        end
    end

    assign pwm_a         = pwm_a_q;
    assign pwm_b         = pwm_b_q;
    assign period_start  = pstart_q;
    assign fault_latched = fault_q;
    assign duty_active   = duty_q;

endmodule
